// File: rtl/keypad_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_event_ctrl
//  Description : Turns the column-slot pulses of the keypad scan decoder into
//                debounced, one-per-press key events, with no auto-repeat.
//                The events are queued in a small valid/ready FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_event_ctrl #(
  parameter int FRAME_CYCLES    = 450_000,
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk_100MHz,
  input  logic                          reset,
  input  logic                          button_pressed,
  input  logic [3:0]                    dec_out,
  input  logic                          key_ready,
  output logic                          key_valid,
  output logic [3:0]                    key_code,
  output logic                          key_down,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int HW = ($clog2(FRAME_CYCLES + 1) > 0) ? $clog2(FRAME_CYCLES + 1) : 1;
  localparam int DW = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [HW-1:0] c_HOLD_LOAD = HW'(FRAME_CYCLES);
  localparam logic [DW-1:0] c_DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] c_DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    c_IDLE     = 2'd0,
    c_DEBOUNCE = 2'd1,
    c_HELD     = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [3:0]      r_cand;
  logic [3:0]      w_cand_nxt;
  logic [DW-1:0]   r_deb;
  logic [DW-1:0]   w_deb_nxt;
  logic [HW-1:0]   r_hold;
  logic            w_released;
  logic            w_push;
  logic            w_pop;
  logic            w_push_ok;

  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_overflow;

  // The hold window bridges the gaps between column slots of one scan frame.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
    end else if (button_pressed) begin
      r_hold <= c_HOLD_LOAD;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - HW'(1);
    end
  end

  assign w_released = !button_pressed && (r_hold == '0);
  assign key_down   = button_pressed || (r_hold != '0);

  // Press-tracking state: current state, candidate code and debounce count.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      r_state <= c_IDLE;
      r_cand  <= '0;
      r_deb   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  // Next-state decode; inside DEBOUNCE a release beats a code change beats counting.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_deb_nxt   = r_deb;
    w_push      = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (button_pressed) begin
          w_cand_nxt  = dec_out;
          w_deb_nxt   = '0;
          w_state_nxt = c_DEBOUNCE;
        end
      end
      c_DEBOUNCE: begin
        if (w_released) begin
          w_state_nxt = c_IDLE;
        end else if (button_pressed && (dec_out != r_cand)) begin
          w_cand_nxt = dec_out;
          w_deb_nxt  = '0;
        end else if (r_deb == c_DEB_LAST) begin
          w_push      = 1'b1;
          w_state_nxt = c_HELD;
        end else begin
          w_deb_nxt = r_deb + DW'(1);
        end
      end
      c_HELD: begin
        if (w_released) begin
          w_state_nxt = c_IDLE;
        end else if (button_pressed && (dec_out != r_cand)) begin
          // Rollover to a new key without a release: debounce the new code.
          w_cand_nxt  = dec_out;
          w_deb_nxt   = '0;
          w_state_nxt = c_DEBOUNCE;
        end
      end
      default: begin
        w_state_nxt = c_IDLE;
      end
    endcase
  end

  // A push into a full queue still fits when the head leaves in the same cycle.
  assign w_pop     = (r_count != '0) && key_ready;
  assign w_push_ok = w_push && ((r_count < c_DEPTH) || w_pop);

  // Event queue storage, pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= r_cand;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push && !w_push_ok) begin
        r_overflow <= 1'b1;
      end
      if (w_push_ok && !w_pop) begin
        r_count <= r_count + CW'(1);
      end else if (!w_push_ok && w_pop) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  assign key_valid  = (r_count != '0);
  assign key_code   = r_mem[r_rd_ptr];
  assign fifo_count = r_count;
  assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_event_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_event_ctrl
//  Description : Directed, self-checking bench for keypad_event_ctrl using
//                small frame/debounce windows.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_event_ctrl;

  localparam int FRAME    = 8;
  localparam int DEBOUNCE = 20;
  localparam int DEPTH    = 4;

  logic       clk;
  logic       rst;
  logic       bp;
  logic [3:0] dec;
  logic       rdy;
  logic       kvalid;
  logic [3:0] kcode;
  logic       kdown;
  logic [2:0] kcount;
  logic       kovf;

  int n_chk;
  int n_err;

  typedef struct {
    logic       bp;
    logic [3:0] code;
    logic       rdy;
    logic       e_valid;
    logic [3:0] e_code;
    logic [2:0] e_cnt;
    logic       e_down;
    logic       e_ovf;
  } vec_t;

  vec_t t1 [60];

  keypad_event_ctrl #(
    .FRAME_CYCLES   (FRAME),
    .DEBOUNCE_CYCLES(DEBOUNCE),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk_100MHz    (clk),
    .reset         (rst),
    .button_pressed(bp),
    .dec_out       (dec),
    .key_ready     (rdy),
    .key_valid     (kvalid),
    .key_code      (kcode),
    .key_down      (kdown),
    .fifo_count    (kcount),
    .overflow      (kovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs set before this are sampled at the next edge; outputs read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic b, input logic [3:0] c, input logic r);
    bp  = b;
    dec = c;
    rdy = r;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) begin
      drive(1'b0, 4'h0, r);
      tick();
    end
  endtask

  task automatic press(input logic [3:0] c, input int len, input logic r);
    for (int i = 0; i < len; i++) begin
      drive(1'b1, c, r);
      tick();
    end
  endtask

  initial begin
    logic [3:0] exp4 [4];
    logic [3:0] exp6 [4];
    logic       ev;
    logic [3:0] ec;

    n_chk = 0;
    n_err = 0;
    exp4[0] = 4'h1; exp4[1] = 4'h2; exp4[2] = 4'h3; exp4[3] = 4'h4;
    exp6[0] = 4'h2; exp6[1] = 4'h3; exp6[2] = 4'h4; exp6[3] = 4'h8;

    // Scenario 1 table: code 5 pulsing one slot in four, consumer always ready.
    for (int c = 0; c < 60; c++) begin
      t1[c].bp      = (c % 4 == 0);
      t1[c].code    = 4'h5;
      t1[c].rdy     = 1'b1;
      t1[c].e_valid = (c == 20);
      t1[c].e_code  = 4'h5;
      t1[c].e_cnt   = (c == 20) ? 3'd1 : 3'd0;
      t1[c].e_down  = 1'b1;
      t1[c].e_ovf   = 1'b0;
    end

    // Reset state
    rst = 1'b1;
    drive(1'b0, 4'h0, 1'b0);
    tick();
    tick();
    chk("reset_valid", 32'(kvalid), 32'd0);
    chk("reset_count", 32'(kcount), 32'd0);
    chk("reset_ovf",   32'(kovf),   32'd0);
    chk("reset_down",  32'(kdown),  32'd0);
    chk("reset_code",  32'(kcode),  32'd0);
    #2 rst = 1'b0;

    // Scenario 1: one event, no repeat while held
    for (int c = 0; c < 60; c++) begin
      drive(t1[c].bp, t1[c].code, t1[c].rdy);
      tick();
      chk($sformatf("s1_valid[%0d]", c), 32'(kvalid), 32'(t1[c].e_valid));
      chk($sformatf("s1_count[%0d]", c), 32'(kcount), 32'(t1[c].e_cnt));
      chk($sformatf("s1_down[%0d]", c),  32'(kdown),  32'(t1[c].e_down));
      chk($sformatf("s1_ovf[%0d]", c),   32'(kovf),   32'(t1[c].e_ovf));
      if (t1[c].e_valid)
        chk($sformatf("s1_code[%0d]", c), 32'(kcode), 32'(t1[c].e_code));
    end
    idle(12, 1'b1);

    // Scenario 2: short glitch, no event, key_down drops 8 cycles after the last pulse
    for (int c = 0; c < 26; c++) begin
      drive((c == 0) || (c == 4) || (c == 8), 4'h9, 1'b1);
      tick();
      chk($sformatf("s2_valid[%0d]", c), 32'(kvalid), 32'd0);
      chk($sformatf("s2_down[%0d]", c),  32'(kdown),  32'(c <= 15));
    end

    // Scenario 3: code 3 held, then rollover to code 7 without release
    for (int c = 0; c < 71; c++) begin
      drive((c < 40) ? 1'b1 : (c % 4 == 0), (c < 40) ? 4'h3 : 4'h7, 1'b1);
      tick();
      ev = (c == 20) || (c == 60);
      ec = (c == 20) ? 4'h3 : 4'h7;
      chk($sformatf("s3_valid[%0d]", c), 32'(kvalid), 32'(ev));
      if (ev)
        chk($sformatf("s3_code[%0d]", c), 32'(kcode), 32'(ec));
    end
    idle(12, 1'b1);

    // Scenario 4: five presses with no consumer -> full and overflow
    for (int k = 0; k < 5; k++) begin
      press((k == 4) ? 4'h6 : 4'(k + 1), 25, 1'b0);
      idle(12, 1'b0);
      chk($sformatf("s4_count[%0d]", k), 32'(kcount), (k < 4) ? 32'(k + 1) : 32'd4);
      chk($sformatf("s4_ovf[%0d]", k),   32'(kovf),   32'(k == 4));
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s4_valid[%0d]", i), 32'(kvalid), 32'd1);
      chk($sformatf("s4_drain[%0d]", i), 32'(kcode),  32'(exp4[i]));
      drive(1'b0, 4'h0, 1'b1);
      tick();
    end
    chk("s4_empty_valid", 32'(kvalid), 32'd0);
    chk("s4_empty_count", 32'(kcount), 32'd0);
    tick();
    chk("s4_ready_empty_count", 32'(kcount), 32'd0);
    chk("s4_ovf_sticky",        32'(kovf),   32'd1);

    // Scenario 5: async reset in the middle of debouncing a held key
    press(4'hA, 11, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_valid", 32'(kvalid), 32'd0);
    chk("s5_rst_count", 32'(kcount), 32'd0);
    chk("s5_rst_ovf",   32'(kovf),   32'd0);
    chk("s5_rst_code",  32'(kcode),  32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    for (int p = 0; p < 30; p++) begin
      drive(1'b1, 4'hA, 1'b1);
      tick();
      chk($sformatf("s5_valid[%0d]", p), 32'(kvalid), 32'(p == 20));
      if (p == 20)
        chk("s5_code", 32'(kcode), 32'hA);
    end
    idle(12, 1'b1);

    // Scenario 6: push and pop together while full
    for (int k = 0; k < 4; k++) begin
      press(4'(k + 1), 25, 1'b0);
      idle(12, 1'b0);
    end
    chk("s6_full_count", 32'(kcount), 32'd4);
    for (int c = 0; c < 25; c++) begin
      drive(1'b1, 4'h8, (c == 20));
      tick();
      if (c == 20) begin
        chk("s6_count", 32'(kcount), 32'd4);
        chk("s6_ovf",   32'(kovf),   32'd0);
        chk("s6_head",  32'(kcode),  32'd2);
      end
    end
    idle(12, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("s6_drain[%0d]", i), 32'(kcode), 32'(exp6[i]));
      drive(1'b0, 4'h0, 1'b1);
      tick();
    end
    chk("s6_empty_count", 32'(kcount), 32'd0);
    chk("s6_ovf_final",   32'(kovf),   32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
